load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Sits directly upstream of the data memory, between the core's execute stage and the 64 x 32-bit word-addressed D-MEM. Accepts byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/ready handshake. Converts each request to word-indexed memory accesses, performing read-modify-write for sub-word stores. Returns aligned, sign/zero-extended load data over a valid/ready response channel.

Parameters:
MEM_WORDS, 64, number of 32-bit words in D-MEM; byte addresses >= 4*MEM_WORDS are out of range
IDX_W, 6, word-index width, log2(MEM_WORDS)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset (reset==0 resets)
req_valid  in  1  request present
req_ready  out  1  LSU can accept a request this cycle
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_store  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data; low byte/half used for SB/SH
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  access faulted; no memory write occurred
mem_addr  out  32  word index, zero-extended req_addr[IDX_W+1:2]
mem_wdata  out  32  write word to D-MEM
mem_read  out  1  D-MEM read enable (D-MEM read is asynchronous)
mem_write  out  1  D-MEM write enable (D-MEM writes on rising edge)
mem_rdata  in  32  D-MEM read word

Behaviour:
- Reset (reset==0, async): state=IDLE; resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_wdata=0, merge/addr regs=0. D-MEM contents are not touched. Reset during MERGE aborts with no write.
- Request fires on req_valid && req_ready; req_ready = (state==IDLE).
- Fault check at accept: out of range (req_addr >= 4*MEM_WORDS) or misaligned (H/HU with addr[0]!=0, W with addr[1:0]!=0), or illegal funct3 (011, 110, 111, or store with funct3 100/101). Faulting request goes to RESP with resp_err=1, resp_rdata=0, and issues no mem_read/mem_write.
- States IDLE, MERGE, RESP.
- IDLE, load accepted: mem_read=1 combinationally that cycle. Capture mem_rdata, then select byte by addr[1:0] or half by addr[1]. Sign-extend B/H; zero-extend BU/HU. Register the result into resp_rdata and go to RESP. Latency is 1 cycle from accept to resp_valid.
- IDLE, SW accepted: mem_write=1, mem_wdata=req_wdata that cycle. Go to RESP.
- IDLE, SB/SH accepted: mem_read=1 that cycle. Latch the word, byte offset, size and store data, then go to MERGE.
- MERGE: mem_write=1, mem_addr=latched index, mem_wdata=latched word with the target byte/half replaced. Go to RESP. Latency is 2 cycles from accept to resp_valid.
- RESP: resp_valid=1 with resp_rdata/resp_err held stable until resp_ready. On resp_ready, go to IDLE; the next request is accepted no earlier than the following cycle.
- mem_read and mem_write are never both 1. Both are 0 in RESP and in IDLE with no request. mem_addr/mem_wdata are don't-care (drive 0) when the enables are low.
- Store responses: resp_rdata=0.

Optional Feature:
LSU_STRICT_ALIGN_EN: when defined, misaligned H/HU/W accesses fault as above. When undefined, misalignment is never a fault: address low bits are masked (H: addr[0] ignored; W: addr[1:0] ignored) and the access proceeds on the aligned location. Range and illegal-funct3 faults apply in both builds.

Test Plan:
- Reset: hold reset=0 with req_valid=1 -> req_ready=0, resp_valid=0, mem_write=0. Release -> req_ready=1.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_write pulses one cycle with mem_addr=4. Load response arrives 1 cycle after accept with resp_rdata=0xDEADBEEF, resp_err=0.
- After the above: SB addr 0x11 data 0x000000A5 -> mem_read cycle, then mem_write cycle with mem_wdata=0xDEADA5EF. Then LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
- Faults: LW 0x100 (out of range) and, with LSU_STRICT_ALIGN_EN, SH 0x13 -> resp_err=1, resp_rdata=0, no mem_write, and a later LW 0x10 is unchanged. Without the macro, SH 0x13 writes the half at 0x12.
- Backpressure: load response with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout, and no memory enables asserted.
- Reset mid-RMW: assert reset=0 while in MERGE -> no mem_write pulse. After release, LW of that word returns the pre-store value.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed D-MEM; sub-word stores use read-modify-write.
// Build option: define LSU_STRICT_ALIGN_EN to fault misaligned H/HU/W accesses instead of masking the address.
module load_store_unit #(
  parameter int MEM_WORDS = 64,
  parameter int IDX_W     = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, MERGE, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      merge_q;

  logic             fire;
  logic             range_err;
  logic             align_err;
  logic             f3_err;
  logic             fault;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      load_val;
  logic [31:0]      merged;

  // Gate with reset so a request held during reset never reaches D-MEM.
  assign req_ready  = (state == IDLE) && reset;
  assign resp_valid = (state == RESP);
  assign fire       = req_valid && req_ready;
  assign idx        = req_addr[IDX_W+1:2];
  assign range_err  = req_addr >= 32'(4 * MEM_WORDS);

  always_comb begin
    f3_err = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_err = 1'b0;
      3'b100, 3'b101:         f3_err = req_store;
      default:                f3_err = 1'b1;
    endcase
  end

`ifdef LSU_STRICT_ALIGN_EN
  assign align_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign off       = req_addr[1:0];
`else
  assign align_err = 1'b0;
  assign off       = (req_funct3[1:0] == 2'b01) ? {req_addr[1], 1'b0} :
                     (req_funct3[1:0] == 2'b10) ? 2'b00 : req_addr[1:0];
`endif

  assign fault  = range_err || align_err || f3_err;
  assign byte_v = mem_rdata[{off, 3'b000} +: 8];
  assign half_v = mem_rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_val = mem_rdata;
    case (req_funct3)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_val = {24'd0, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (req_funct3[1:0] == 2'b00)
      merged[{off, 3'b000} +: 8] = req_wdata[7:0];
    else
      merged[{off[1], 4'b0000} +: 16] = req_wdata[15:0];
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (state == MERGE && reset) begin
      mem_write = 1'b1;
      mem_addr  = 32'(idx_q);
      mem_wdata = merge_q;
    end else if (fire && !fault) begin
      mem_addr = 32'(idx);
      if (req_store && req_funct3 == 3'b010) begin
        mem_write = 1'b1;
        mem_wdata = req_wdata;
      end else begin
        mem_read = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      idx_q      <= '0;
      merge_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            resp_err   <= fault;
            resp_rdata <= 32'd0;
            if (fault) begin
              state <= RESP;
            end else if (!req_store) begin
              resp_rdata <= load_val;
              state      <= RESP;
            end else if (req_funct3 == 3'b010) begin
              state <= RESP;
            end else begin
              idx_q   <= idx;
              merge_q <= merged;
              state   <= MERGE;
            end
          end
        end
        MERGE: state <= RESP;
        RESP:  if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
